vram_arbiter_m: RTL and testbench
=================================

// Module: vram_arbiter_m
// PURPOSE
//  Shares the single-port synchronous VRAM between the CPU (bus window
//  0x3700-0x3fff, offset address 0x000-0x8ff) and the GPU fetch pipeline.
//  It grants the port each cycle. The GPU has priority. A starvation counter
//  guarantees CPU progress. The CPU is stalled through cpu_ready (drives 6502 RDY).
// PARAMETERS
//  ADDR_W      12    VRAM address width (both requesters, VRAM port)
//  DATA_W      8     VRAM data width
//  VRAM_DEPTH  2304  valid words; addresses >= VRAM_DEPTH are out of range
//  STARVE_MAX  4     max consecutive GPU grants while CPU waits (>=1)
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  rst         in   1       asynchronous, active-high reset
//  cpu_req     in   1       CPU VRAM access pending (SELECT_vram & valid cycle)
//  cpu_we      in   1       1=write, 0=read; stable while cpu_req && !cpu_ready
//  cpu_addr    in   ADDR_W  offset address (cpu_address - 0x3700)
//  cpu_wdata   in   DATA_W  write data
//  cpu_rdata   out  DATA_W  read data, valid while cpu_ready && cpu_req
//  cpu_ready   out  1       0 = stall CPU
//  gpu_req     in   1       GPU read request this cycle
//  gpu_addr    in   ADDR_W  GPU read address
//  gpu_gnt     out  1       GPU request accepted this cycle (comb.)
//  gpu_valid   out  1       gpu_rdata valid (1 cycle after gpu_gnt)
//  gpu_rdata   out  DATA_W  GPU read data
//  vram_addr   out  ADDR_W  VRAM address
//  vram_we     out  1       VRAM write strobe
//  vram_wdata  out  DATA_W  VRAM write data
//  vram_rdata  in   DATA_W  VRAM read data, 1-cycle latency after vram_addr
// BEHAVIOUR
//  - FSM: IDLE -> CPU_ACC -> CPU_DONE -> IDLE.
//    - IDLE: the CPU may win the port.
//    - CPU_ACC: the port is owned by the CPU. gpu_gnt=0.
//    - CPU_DONE: cpu_ready=1. The CPU is not eligible. The GPU may be granted.
//  - Arbitration in IDLE:
//    - gpu_req && (!cpu_req || starve_cnt<STARVE_MAX): grant GPU.
//    - Otherwise, if cpu_req: grant CPU, next state CPU_ACC.
//  - starve_cnt:
//    - +1 on each GPU grant in IDLE with cpu_req=1, saturating at STARVE_MAX.
//    - Cleared on CPU grant or when cpu_req=0.
//  - CPU transaction: granted in cycle G (vram_addr=cpu_addr; vram_we=cpu_we).
//    - Read: vram_rdata is captured into cpu_rdata at the end of G+1.
//    - cpu_ready=1 in G+2 (CPU_DONE). Minimum CPU latency is 3 cycles.
//  - cpu_ready = !cpu_req | (state==CPU_DONE). Combinational.
//  - cpu_rdata holds its last value until the next CPU read completes.
//  - GPU: gpu_gnt in cycle N gives gpu_valid=1 and gpu_rdata=vram_rdata in N+1.
//    - Fully pipelined: one grant per cycle is possible.
//    - A non-granted request is dropped. The GPU retries.
//  - Idle port: vram_addr=0, vram_we=0, vram_wdata=0.
//  - Out of range (addr >= VRAM_DEPTH):
//    - CPU write: vram_we forced 0.
//    - CPU read: returns 0.
//    - GPU read: gpu_rdata=0.
//    - Handshake timing is unchanged in all cases.
//  - Reset (async, any state, including mid-transaction):
//    - state=IDLE, starve_cnt=0, cpu_rdata=0, gpu_valid=0, gpu_rdata=0.
//    - gpu_gnt=0 and vram_we=0 while rst=1.
//    - cpu_ready=!cpu_req.
//    - An interrupted CPU transaction restarts from arbitration after release.
//  - Simultaneous first requests in IDLE with starve_cnt=0: the GPU wins.
// TESTING
//  - CPU write 0xA5 to 0x123, no GPU: vram_we=1 in G, cpu_ready=1 at G+2.
//    Read-back of 0x123 returns 0xA5.
//  - GPU req every cycle, addr 0..15: gpu_valid every cycle, data 1 cycle late.
//    No gaps.
//  - GPU req continuous + CPU read with STARVE_MAX=4: CPU granted after exactly
//    4 GPU grants. gpu_gnt=0 during CPU_ACC only.
//  - CPU write to 0x900 and 0xFFF: vram_we stays 0. CPU read of 0x900 returns 0.
//    cpu_ready still asserts at G+2.
//  - rst pulsed during CPU_ACC: outputs reach reset values asynchronously.
//    After release with cpu_req held, the access re-arbitrates and completes in 3 cycles.
//  - cpu_req held through CPU_DONE with a GPU req in that cycle: GPU granted.
//    No duplicate CPU access.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus bundle: CPU requester, GPU fetch requester and the VRAM port.
// slave = arbiter side, master = environment (CPU, GPU, VRAM) side.
interface vram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              gpu_req;
    logic [ADDR_W-1:0] gpu_addr;
    logic              gpu_gnt;
    logic              gpu_valid;
    logic [DATA_W-1:0] gpu_rdata;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_we;
    logic [DATA_W-1:0] vram_wdata;
    logic [DATA_W-1:0] vram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, gpu_req, gpu_addr, vram_rdata,
        output cpu_rdata, cpu_ready, gpu_gnt, gpu_valid, gpu_rdata,
        output vram_addr, vram_we, vram_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, gpu_req, gpu_addr, vram_rdata,
        input  cpu_rdata, cpu_ready, gpu_gnt, gpu_valid, gpu_rdata,
        input  vram_addr, vram_we, vram_wdata
    );
endinterface

// File: rtl/vram_arbiter_m.sv
// Single-port VRAM arbiter: GPU priority per cycle, CPU guaranteed a slot after
// STARVE_MAX consecutive GPU grants. CPU access takes 3 cycles; GPU reads are pipelined.
module vram_arbiter_m #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int VRAM_DEPTH = 2304,
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    vram_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CPU_ACC  = 2'd1;
    localparam logic [1:0] S_CPU_DONE = 2'd2;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic             cnt_under;
    logic             gpu_win;
    logic             cpu_win;
    logic             cpu_oor;
    logic             gpu_oor;
    logic             gpu_valid_q;
    logic             gpu_oor_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    assign cpu_oor   = 32'(bus.cpu_addr) >= 32'(VRAM_DEPTH);
    assign gpu_oor   = 32'(bus.gpu_addr) >= 32'(VRAM_DEPTH);
    assign cnt_under = 32'(starve_cnt) < 32'(STARVE_MAX);

    // CPU_DONE hands the port to the GPU so a held cpu_req cannot re-win immediately
    assign gpu_win = !rst && bus.gpu_req &&
                     (((state == S_IDLE) && (!bus.cpu_req || cnt_under)) ||
                      (state == S_CPU_DONE));
    assign cpu_win = !rst && (state == S_IDLE) && bus.cpu_req && !gpu_win;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (cpu_win) state_nxt = S_CPU_ACC;
            S_CPU_ACC:  state_nxt = S_CPU_DONE;
            S_CPU_DONE: state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.vram_addr  = '0;
        bus.vram_we    = 1'b0;
        bus.vram_wdata = '0;
        if (cpu_win) begin
            bus.vram_addr  = bus.cpu_addr;
            bus.vram_we    = bus.cpu_we && !cpu_oor;
            bus.vram_wdata = bus.cpu_wdata;
        end else if (gpu_win) begin
            bus.vram_addr  = bus.gpu_addr;
        end else if (state == S_CPU_ACC) begin
            bus.vram_addr  = bus.cpu_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            starve_cnt  <= '0;
            cpu_rdata_q <= '0;
            gpu_valid_q <= 1'b0;
            gpu_oor_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            gpu_valid_q <= gpu_win;
            gpu_oor_q   <= gpu_oor;
            if (cpu_win || !bus.cpu_req)
                starve_cnt <= '0;
            else if ((state == S_IDLE) && gpu_win && cnt_under)
                starve_cnt <= starve_cnt + CNT_W'(1);
            // read data issued in the grant cycle lands during CPU_ACC
            if ((state == S_CPU_ACC) && !bus.cpu_we)
                cpu_rdata_q <= cpu_oor ? '0 : bus.vram_rdata;
        end
    end

    assign bus.gpu_gnt   = gpu_win;
    assign bus.gpu_valid = gpu_valid_q;
    assign bus.gpu_rdata = (gpu_valid_q && !gpu_oor_q) ? bus.vram_rdata : '0;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ready = !bus.cpu_req || (state == S_CPU_DONE);
endmodule

// File: tb/tb_vram_arbiter_m.sv
// Directed bench for vram_arbiter_m with a behavioural 1-cycle-latency VRAM.
// Unwritten VRAM words read as (addr[7:0] ^ 0x5A), so out-of-range zeros are visible.
module tb_vram_arbiter_m;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad   = 0;

    vram_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    vram_arbiter_m #(.ADDR_W(12), .DATA_W(8), .VRAM_DEPTH(2304), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    bit       written [0:4095];
    bit [7:0] wval    [0:4095];
    always @(posedge clk) begin
        if (bus.vram_we) begin
            written[bus.vram_addr] <= 1'b1;
            wval[bus.vram_addr]    <= bus.vram_wdata;
        end
        bus.vram_rdata <= written[bus.vram_addr] ? wval[bus.vram_addr]
                                                 : (bus.vram_addr[7:0] ^ 8'h5A);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.gpu_req = 1'b0; bus.gpu_addr = '0;
    endtask

    // Called at posedge+1; returns at posedge+1 after dropping cpu_req.
    task automatic cpu_access(input logic we, input logic [11:0] addr, input logic [7:0] wd,
                              output int lat, output logic first_we, output logic [7:0] rd);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        lat = 0; first_we = 1'b0; rd = '0;
        forever begin
            @(negedge clk);
            lat++;
            if (lat == 1) first_we = bus.vram_we;
            if (bus.cpu_ready) begin
                rd = bus.cpu_rdata;
                break;
            end
            if (lat > 20) begin
                check("cpu_access_timeout", 32'(lat), 32'd3);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
    endtask

    typedef struct {
        logic        cpu_req;
        logic        cpu_we;
        logic [11:0] cpu_addr;
        logic [7:0]  cpu_wdata;
        logic        gpu_req;
        logic [11:0] gpu_addr;
        logic        e_gnt;
        logic        e_we;
        logic [11:0] e_addr;
        logic [7:0]  e_wdata;
        logic        e_ready;
        logic        e_gvalid;
        logic [7:0]  e_grdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat;
        logic fwe;
        logic [7:0] rd;
        logic [6:0] exp_gnt;
        logic [6:0] exp_rdy;

        //          creq we  caddr    wd     greq gaddr    gnt we addr     wdata  rdy gv grd
        vecs[0] = '{1'b0,1'b0,12'h000,8'h00, 1'b0,12'h000, 1'b0,1'b0,12'h000,8'h00, 1'b1,1'b0,8'h00};
        vecs[1] = '{1'b0,1'b0,12'h000,8'h00, 1'b1,12'h010, 1'b1,1'b0,12'h010,8'h00, 1'b1,1'b1,8'h4A};
        vecs[2] = '{1'b1,1'b1,12'h123,8'h3C, 1'b0,12'h000, 1'b0,1'b1,12'h123,8'h3C, 1'b0,1'b0,8'h00};
        vecs[3] = '{1'b1,1'b0,12'h200,8'h00, 1'b1,12'h055, 1'b1,1'b0,12'h055,8'h00, 1'b0,1'b1,8'h0F};
        vecs[4] = '{1'b1,1'b1,12'h900,8'h77, 1'b0,12'h000, 1'b0,1'b0,12'h900,8'h77, 1'b0,1'b0,8'h00};
        vecs[5] = '{1'b1,1'b1,12'hFFF,8'h88, 1'b0,12'h000, 1'b0,1'b0,12'hFFF,8'h88, 1'b0,1'b0,8'h00};
        vecs[6] = '{1'b0,1'b0,12'h000,8'h00, 1'b1,12'hFFF, 1'b1,1'b0,12'hFFF,8'h00, 1'b1,1'b1,8'h00};

        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_ready",  32'(bus.cpu_ready), 32'd1);
        check("rst_cpu_rdata",  32'(bus.cpu_rdata), 32'd0);
        check("rst_gpu_valid",  32'(bus.gpu_valid), 32'd0);
        check("rst_vram_we",    32'(bus.vram_we),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            bus.cpu_req = vecs[i].cpu_req; bus.cpu_we = vecs[i].cpu_we;
            bus.cpu_addr = vecs[i].cpu_addr; bus.cpu_wdata = vecs[i].cpu_wdata;
            bus.gpu_req = vecs[i].gpu_req; bus.gpu_addr = vecs[i].gpu_addr;
            @(negedge clk);
            check($sformatf("v%0d_gpu_gnt", i),    32'(bus.gpu_gnt),    32'(vecs[i].e_gnt));
            check($sformatf("v%0d_vram_we", i),    32'(bus.vram_we),    32'(vecs[i].e_we));
            check($sformatf("v%0d_vram_addr", i),  32'(bus.vram_addr),  32'(vecs[i].e_addr));
            check($sformatf("v%0d_vram_wdata", i), 32'(bus.vram_wdata), 32'(vecs[i].e_wdata));
            check($sformatf("v%0d_cpu_ready", i),  32'(bus.cpu_ready),  32'(vecs[i].e_ready));
            @(posedge clk); #1;
            drive_idle();
            @(negedge clk);
            check($sformatf("v%0d_gpu_valid", i),  32'(bus.gpu_valid),  32'(vecs[i].e_gvalid));
            check($sformatf("v%0d_gpu_rdata", i),  32'(bus.gpu_rdata),  32'(vecs[i].e_grdata));
            repeat (3) @(posedge clk);
            #1;
        end

        // CPU write then read-back, no GPU traffic
        cpu_access(1'b1, 12'h123, 8'hA5, lat, fwe, rd);
        check("wr123_we_in_G", 32'(fwe), 32'd1);
        check("wr123_latency", 32'(lat), 32'd3);
        cpu_access(1'b0, 12'h123, 8'h00, lat, fwe, rd);
        check("rd123_latency", 32'(lat), 32'd3);
        check("rd123_data",    32'(rd),  32'hA5);

        // GPU streaming addresses 0..15, one grant per cycle
        for (int i = 0; i <= 16; i++) begin
            bus.gpu_req  = (i < 16);
            bus.gpu_addr = 12'(i & 15);
            @(negedge clk);
            check($sformatf("stream%0d_gnt", i), 32'(bus.gpu_gnt), 32'(i < 16));
            if (i > 0) begin
                check($sformatf("stream%0d_valid", i), 32'(bus.gpu_valid), 32'd1);
                check($sformatf("stream%0d_rdata", i), 32'(bus.gpu_rdata),
                      32'(8'(i - 1) ^ 8'h5A));
            end
            @(posedge clk); #1;
        end
        drive_idle();
        @(posedge clk); #1;

        // Continuous GPU plus CPU read: CPU wins after exactly 4 GPU grants
        exp_gnt = 7'b1001111;
        exp_rdy = 7'b1000000;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h020;
        for (int k = 0; k < 7; k++) begin
            bus.gpu_req  = 1'b1;
            bus.gpu_addr = 12'h030 + 12'(k);
            @(negedge clk);
            check($sformatf("starve%0d_gnt", k),   32'(bus.gpu_gnt),   32'(exp_gnt[k]));
            check($sformatf("starve%0d_ready", k), 32'(bus.cpu_ready), 32'(exp_rdy[k]));
            if (k == 6) begin
                check("starve_done_addr",  32'(bus.vram_addr), 32'h036);
                check("starve_done_we",    32'(bus.vram_we),   32'd0);
                check("starve_cpu_rdata",  32'(bus.cpu_rdata), 32'h7A);
            end
            @(posedge clk); #1;
        end
        drive_idle();
        @(posedge clk); #1;

        // Out-of-range CPU accesses
        cpu_access(1'b1, 12'h900, 8'h11, lat, fwe, rd);
        check("oor900_we",      32'(fwe), 32'd0);
        check("oor900_latency", 32'(lat), 32'd3);
        cpu_access(1'b1, 12'hFFF, 8'h22, lat, fwe, rd);
        check("oorFFF_we",      32'(fwe), 32'd0);
        cpu_access(1'b0, 12'h900, 8'h00, lat, fwe, rd);
        check("oor900_rdata",   32'(rd),  32'h00);
        check("oor900_rd_lat",  32'(lat), 32'd3);

        // Reset during CPU_ACC, then re-arbitration with cpu_req held
        cpu_access(1'b0, 12'h010, 8'h00, lat, fwe, rd);
        check("pre_rst_rdata", 32'(rd), 32'h4A);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h123;
        @(posedge clk); #2;
        rst = 1'b1;
        bus.gpu_req = 1'b1; bus.gpu_addr = 12'h005;
        #1;
        check("arst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        check("arst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        check("arst_gpu_gnt",   32'(bus.gpu_gnt),   32'd0);
        check("arst_vram_we",   32'(bus.vram_we),   32'd0);
        check("arst_gpu_valid", 32'(bus.gpu_valid), 32'd0);
        check("arst_gpu_rdata", 32'(bus.gpu_rdata), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.gpu_req = 1'b0;
        cpu_access(1'b0, 12'h123, 8'h00, lat, fwe, rd);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_rdata",   32'(rd),  32'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
